// File: rtl/autoc_preamble_tx_if.sv
// Payload stream into the preamble transmitter: valid/ready handshake, one sample per transfer.
interface autoc_preamble_tx_if #(
  parameter int WIDTH = 16
);
  logic [WIDTH-1:0] pl_data;
  logic             pl_valid;
  logic             pl_ready;

  modport master (output pl_data, output pl_valid, input  pl_ready);
  modport slave  (input  pl_data, input  pl_valid, output pl_ready);
endinterface

// File: rtl/autoc_preamble_tx.sv
// Framed burst transmitter: LFSR +/-A preamble repeated `reps` times, then a pass-through payload.
// Optional zero-valued guard period after the preamble is enabled by defining AUTOC_TX_GUARD_EN.
module autoc_preamble_tx #(
  parameter int WIDTH = 16,
  parameter int DELAY = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [7:0]              reps,
  input  logic [WIDTH-1:0]        amplitude,
  input  logic [15:0]             payload_len,
  autoc_preamble_tx_if.slave      pl,
  output logic [WIDTH-1:0]        sample_out,
  output logic                    strobe,
  output logic                    busy,
  output logic                    done
);

  localparam int              CW   = $clog2(DELAY);
  localparam logic [CW-1:0]   LAST = CW'(DELAY - 1);
  localparam logic [6:0]      SEED = 7'h7F;
  localparam logic [WIDTH-1:0] AMAX = {1'b0, {(WIDTH-1){1'b1}}};
`ifdef AUTOC_TX_GUARD_EN
  localparam bit GUARD_EN = 1'b1;
`else
  localparam bit GUARD_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    IDLE,
    PREAMBLE,
`ifdef AUTOC_TX_GUARD_EN
    GUARD,
`endif
    PAYLOAD,
    FIN
  } state_t;

  state_t           state, state_n;
  logic [CW-1:0]    samp, samp_n;
  logic [7:0]       rep, rep_n;
  logic [15:0]      xfer, xfer_n;
  logic [6:0]       lfsr, lfsr_n, cur;
  logic [7:0]       reps_q, reps_n;
  logic [WIDTH-1:0] amp_q, amp_n;
  logic [15:0]      len_q, len_n;
  logic [WIDTH-1:0] out_n;
  logic             strobe_n, done_n, ready_n, ready_q;
  logic             emit_pre, last_pre_n;

  function automatic logic [6:0] lfsr_step(input logic [6:0] v);
    return {v[5:0], v[6] ^ v[5]};
  endfunction

  assign pl.pl_ready = ready_q;
  assign busy        = (state != IDLE);

  // Registers hold what is on the output now; the comb block decides the next sample.
  always_comb begin
    state_n    = state;
    samp_n     = samp;
    rep_n      = rep;
    xfer_n     = xfer;
    lfsr_n     = lfsr;
    reps_n     = reps_q;
    amp_n      = amp_q;
    len_n      = len_q;
    cur        = lfsr;
    emit_pre   = 1'b0;
    last_pre_n = 1'b0;
    out_n      = '0;
    strobe_n   = 1'b0;
    done_n     = 1'b0;
    ready_n    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          reps_n = reps;
          amp_n  = amplitude[WIDTH-1] ? AMAX : amplitude;
          len_n  = payload_len;
          samp_n = '0;
          rep_n  = '0;
          xfer_n = '0;
          if (reps != 8'd0) begin
            state_n  = PREAMBLE;
            emit_pre = 1'b1;
            cur      = SEED;
          end else if (payload_len != 16'd0) begin
            state_n = PAYLOAD;
            ready_n = 1'b1;
          end else begin
            state_n = FIN;
            done_n  = 1'b1;
          end
        end
      end
      PREAMBLE: begin
        if (!(samp == LAST && rep == reps_q - 8'd1)) begin
          emit_pre = 1'b1;
          if (samp == LAST) begin
            samp_n = '0;
            rep_n  = rep + 8'd1;
            cur    = SEED;
          end else begin
            samp_n = samp + 1'b1;
          end
          last_pre_n = (samp_n == LAST) && (rep_n == reps_q - 8'd1);
          done_n     = last_pre_n && !GUARD_EN && (len_q == 16'd0);
        end else begin
`ifdef AUTOC_TX_GUARD_EN
          state_n  = GUARD;
          samp_n   = '0;
          strobe_n = 1'b1;
`else
          if (len_q != 16'd0) begin
            state_n = PAYLOAD;
            ready_n = 1'b1;
          end else begin
            state_n = FIN;
          end
`endif
        end
      end
`ifdef AUTOC_TX_GUARD_EN
      GUARD: begin
        if (samp != LAST) begin
          samp_n   = samp + 1'b1;
          strobe_n = 1'b1;
          done_n   = (samp_n == LAST) && (len_q == 16'd0);
        end else if (len_q != 16'd0) begin
          state_n = PAYLOAD;
          ready_n = 1'b1;
        end else begin
          state_n = FIN;
        end
      end
`endif
      PAYLOAD: begin
        ready_n = 1'b1;
        if (pl.pl_valid && ready_q) begin
          out_n    = pl.pl_data;
          strobe_n = 1'b1;
          xfer_n   = xfer + 16'd1;
          if (xfer_n == len_q) begin
            state_n = FIN;
            done_n  = 1'b1;
            ready_n = 1'b0;
          end
        end
      end
      FIN:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
    // Symbol is the LFSR MSB before the shift; -A cannot overflow because A is clamped.
    if (emit_pre) begin
      strobe_n = 1'b1;
      out_n    = cur[6] ? amp_n : -amp_n;
      lfsr_n   = lfsr_step(cur);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      samp       <= '0;
      rep        <= '0;
      xfer       <= '0;
      lfsr       <= SEED;
      reps_q     <= '0;
      amp_q      <= '0;
      len_q      <= '0;
      sample_out <= '0;
      strobe     <= 1'b0;
      done       <= 1'b0;
      ready_q    <= 1'b0;
    end else begin
      state      <= state_n;
      samp       <= samp_n;
      rep        <= rep_n;
      xfer       <= xfer_n;
      lfsr       <= lfsr_n;
      reps_q     <= reps_n;
      amp_q      <= amp_n;
      len_q      <= len_n;
      sample_out <= out_n;
      strobe     <= strobe_n;
      done       <= done_n;
      ready_q    <= ready_n;
    end
  end

endmodule

// File: tb/tb_autoc_preamble_tx.sv
// Directed scoreboard bench for autoc_preamble_tx; guard scenario runs when AUTOC_TX_GUARD_EN is defined.
module tb_autoc_preamble_tx;
  localparam int W = 16;
  localparam int D = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [7:0]   reps = '0;
  logic [W-1:0] amplitude = '0;
  logic [15:0]  payload_len = '0;
  logic [W-1:0] sample_out;
  logic         strobe, busy, done;

  autoc_preamble_tx_if #(.WIDTH(W)) pl_if ();

  autoc_preamble_tx #(.WIDTH(W), .DELAY(D)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .reps        (reps),
    .amplitude   (amplitude),
    .payload_len (payload_len),
    .pl          (pl_if),
    .sample_out  (sample_out),
    .strobe      (strobe),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] s;
    logic         d;
  } exp_t;

  exp_t         q[$];
  logic [W-1:0] got[$];
  int           checks = 0;
  int           errors = 0;
  logic         exp_empty_done = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_pre(input logic [7:0] r, input logic [W-1:0] amp, input logic last_done);
    logic [W-1:0] a, v;
    logic [6:0]   lf;
    a = amp[W-1] ? {1'b0, {(W-1){1'b1}}} : amp;
    for (int rr = 0; rr < int'(r); rr++) begin
      lf = 7'h7F;
      for (int i = 0; i < D; i++) begin
        v = lf[6] ? a : -a;
        q.push_back('{s: v, d: last_done && (rr == int'(r) - 1) && (i == D - 1)});
        lf = {lf[5:0], lf[6] ^ lf[5]};
      end
    end
  endtask

  // Advance one cycle and score whatever the DUT produced.
  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    if (strobe === 1'b1) begin
      got.push_back(sample_out);
      if (q.size() == 0) begin
        chk("extra_strobe", 32'd1, 32'd0);
      end else begin
        e = q.pop_front();
        chk("sample", sample_out, e.s);
        chk("done_on_strobe", done, e.d);
      end
    end else begin
      chk("done_no_strobe", done, exp_empty_done);
    end
  endtask

  task automatic frame(input logic [7:0] r, input logic [W-1:0] amp, input logic [15:0] len);
    reps = r; amplitude = amp; payload_len = len; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic preamble_run(input logic [7:0] r, input logic [W-1:0] amp, input logic [W-1:0] first);
    push_pre(r, amp, 1'b1);
    got.delete();
    frame(r, amp, 16'd0);
    chk("first_sample", sample_out, first);
    chk("busy_start", busy, 1'b1);
    for (int i = 1; i < int'(r) * D; i++) begin
      tick();
      chk("contig_strobe", strobe, 1'b1);
    end
    tick();
    chk("fin_strobe", strobe, 1'b0);
    chk("fin_busy", busy, 1'b1);
    tick();
    chk("idle_busy", busy, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int bad;
    int n;
    logic [6:0] pat;
    pl_if.pl_valid = 1'b0;
    pl_if.pl_data  = '0;

    tick(); tick();
    chk("rst_sample", sample_out, 16'h0);
    chk("rst_strobe", strobe, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_ready", pl_if.pl_ready, 1'b0);
    rst = 1'b0;
    tick();

    // Repetition: 4 x 32 samples
    preamble_run(8'd4, 16'h2000, 16'h2000);
    chk("rep_count", got.size(), 32'd128);
    bad = 0;
    for (int i = 0; i < got.size(); i++)
      if (got[i] != 16'h2000 && got[i] != 16'hE000) bad++;
    for (int i = 0; i < 96 && i + 32 < got.size(); i++)
      if (got[i] != got[i+32]) bad++;
    chk("rep_values_periodic", bad, 32'd0);

    // Clamp
    preamble_run(8'd1, 16'h8000, 16'h7FFF);
    bad = 0;
    for (int i = 0; i < got.size(); i++)
      if (got[i] != 16'h7FFF && got[i] != 16'h8001) bad++;
    chk("clamp_values", bad, 32'd0);
    chk("clamp_count", got.size(), 32'd32);

    // Payload handshake after one repetition
    push_pre(8'd1, 16'h1234, 1'b0);
    frame(8'd1, 16'h1234, 16'd5);
    for (int i = 1; i < D; i++) tick();
    chk("ready_low_in_pre", pl_if.pl_ready, 1'b0);
    tick();
    chk("ready_rise", pl_if.pl_ready, 1'b1);
    chk("gap_strobe", strobe, 1'b0);
    pat = 7'b1101101;
    n = 0;
    for (int k = 0; k < 7; k++) begin
      chk("ready_during_pl", pl_if.pl_ready, 1'b1);
      pl_if.pl_valid = pat[k];
      if (pat[k]) begin
        n++;
        pl_if.pl_data = W'(n);
        q.push_back('{s: W'(n), d: (n == 5)});
      end
      tick();
      chk("pl_strobe_timing", strobe, pat[k]);
    end
    chk("ready_after_last", pl_if.pl_ready, 1'b0);
    chk("pl_fin_busy", busy, 1'b1);
    pl_if.pl_data = 16'd99;
    tick();
    chk("pl_no_extra", strobe, 1'b0);
    chk("pl_idle_busy", busy, 1'b0);
    pl_if.pl_valid = 1'b0;

    // Empty frame
    exp_empty_done = 1'b1;
    frame(8'd0, 16'h1000, 16'd0);
    exp_empty_done = 1'b0;
    chk("empty_busy", busy, 1'b1);
    chk("empty_strobe", strobe, 1'b0);
    tick();
    chk("empty_idle", busy, 1'b0);
    chk("empty_strobe2", strobe, 1'b0);
    tick();

    // Reset mid-frame at preamble sample 40
    push_pre(8'd4, 16'h2000, 1'b1);
    frame(8'd4, 16'h2000, 16'd0);
    for (int i = 1; i <= 40; i++) tick();
    chk("pre_rst_strobe", strobe, 1'b1);
    rst = 1'b1;
    tick();
    chk("mid_rst_strobe", strobe, 1'b0);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_done", done, 1'b0);
    q.delete();
    rst = 1'b0;
    tick();
    preamble_run(8'd4, 16'h2000, 16'h2000);
    chk("restart_count", got.size(), 32'd128);

`ifdef AUTOC_TX_GUARD_EN
    push_pre(8'd2, 16'h2000, 1'b0);
    for (int i = 0; i < D; i++) q.push_back('{s: '0, d: 1'b0});
    frame(8'd2, 16'h2000, 16'd3);
    chk("g_ready0", pl_if.pl_ready, 1'b0);
    for (int i = 1; i < 3 * D; i++) begin
      tick();
      chk("g_strobe", strobe, 1'b1);
      chk("g_ready_low", pl_if.pl_ready, 1'b0);
    end
    tick();
    chk("g_ready_rise", pl_if.pl_ready, 1'b1);
    pl_if.pl_valid = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      pl_if.pl_data = W'(k + 16'h100);
      q.push_back('{s: W'(k + 16'h100), d: (k == 3)});
      tick();
    end
    pl_if.pl_valid = 1'b0;
    chk("g_ready_after", pl_if.pl_ready, 1'b0);
    tick();
    chk("g_idle", busy, 1'b0);
`endif

    chk("queue_drained", q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
